rdwr_protocol_checker: RTL and testbench

RDWR_PROTOCOL_CHECKER -- requirements
Module: rdwr_protocol_checker

---
 rtl/rdwr_chk_pkg.sv | 25 ++
 rtl/rdwr_chk_channel.sv | 185 ++++++++++++++++++
 rtl/rdwr_protocol_checker.sv | 60 ++++++
 tb/tb_rdwr_protocol_checker.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdwr_chk_pkg.sv
// ---------------------------------------------------------------------------
// rdwr_chk_pkg
// Shared types for the read/write protocol checker: per-channel FSM state
// encoding, violation code encoding and the width of a violation code.
// ---------------------------------------------------------------------------
package rdwr_chk_pkg;

   localparam int FC_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } chk_state_e;

   typedef enum logic [FC_W-1:0] {
      FC_NONE    = 3'd0,
      FC_EARLY   = 3'd1,
      FC_TIMEOUT = 3'd2,
      FC_SHORT   = 3'd3,
      FC_OVERLAP = 3'd4,
      FC_ORPHAN  = 3'd5
   } fail_code_e;

endpackage : rdwr_chk_pkg

// File: rtl/rdwr_chk_channel.sv
// ---------------------------------------------------------------------------
// rdwr_chk_channel
// Checks one wr/rd channel: after a wr rise, rd must rise within
// [DLY_MIN, DLY_MAX] edges and then stay high for HOLD_LEN sampled cycles.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                synchronous clear of counter, code and sticky flag
//   wr, rd             request inputs for this channel
//   pass, fail         one-cycle result pulses (registered)
//   fail_code          code of the most recent violation
//   err_cnt            saturating violation counter
//   any_err            sticky "a violation happened" flag
// ---------------------------------------------------------------------------
module rdwr_chk_channel
   import rdwr_chk_pkg::*;
#(
   parameter int DLY_MIN      = 2,
   parameter int DLY_MAX      = 2,
   parameter int HOLD_LEN     = 2,
   parameter int CHECK_ORPHAN = 1,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr,
   input  logic             rd,
   output logic             pass,
   output logic             fail,
   output logic [FC_W-1:0]  fail_code,
   output logic [CNT_W-1:0] err_cnt,
   output logic             any_err
);

   localparam int OFF_W = $clog2(DLY_MAX + 1);
   localparam int HLD_W = $clog2(HOLD_LEN + 1);

   localparam logic [OFF_W-1:0] L_DLY_MIN  = OFF_W'(DLY_MIN);
   localparam logic [OFF_W-1:0] L_DLY_MAX  = OFF_W'(DLY_MAX);
   localparam logic [OFF_W-1:0] L_OFF_ONE  = OFF_W'(1);
   localparam logic [HLD_W-1:0] L_HOLD_LEN = HLD_W'(HOLD_LEN);
   localparam logic [HLD_W-1:0] L_HLD_ONE  = HLD_W'(1);
   localparam logic [CNT_W-1:0] L_CNT_ONE  = CNT_W'(1);

   chk_state_e       r_state;
   chk_state_e       w_state_nxt;
   logic             r_wr_prev;
   logic             r_rd_prev;
   logic [OFF_W-1:0] r_off;
   logic [OFF_W-1:0] w_off_nxt;
   logic [OFF_W-1:0] w_off_cur;
   logic [HLD_W-1:0] r_hold;
   logic [HLD_W-1:0] w_hold_nxt;
   logic [HLD_W-1:0] w_hold_inc;
   logic             r_pass;
   logic             r_fail;
   logic             w_pass_nxt;
   logic             w_fail_nxt;
   fail_code_e       w_code_nxt;
   fail_code_e       r_code;
   logic [CNT_W-1:0] r_cnt;
   logic             r_any;
   logic             w_wr_rise;
   logic             w_rd_rise;

   assign w_wr_rise  = wr & ~r_wr_prev;
   assign w_rd_rise  = rd & ~r_rd_prev;
   // r_off holds the offset of the previous edge; this edge is one further.
   assign w_off_cur  = r_off + L_OFF_ONE;
   assign w_hold_inc = r_hold + L_HLD_ONE;
   assign w_fail_nxt = (w_code_nxt != FC_NONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default before the case so
      // no path leaves a signal unassigned, which would infer a latch.
      w_state_nxt = r_state;
      w_off_nxt   = r_off;
      w_hold_nxt  = r_hold;
      w_pass_nxt  = 1'b0;
      w_code_nxt  = FC_NONE;
      case (r_state)
         ST_IDLE: begin
            if (w_wr_rise) begin
               // A same-edge rd rise counts as an offset-0 rd, always early.
               if (w_rd_rise) begin
                  w_code_nxt = FC_EARLY;
               end else begin
                  w_state_nxt = ST_WAIT;
                  w_off_nxt   = '0;
               end
            end else if (w_rd_rise && (CHECK_ORPHAN != 0)) begin
               w_code_nxt = FC_ORPHAN;
            end
         end
         ST_WAIT: begin
            if (w_wr_rise) begin
               w_code_nxt = FC_OVERLAP;
               w_off_nxt  = '0;
            end else if (w_rd_rise) begin
               if (w_off_cur < L_DLY_MIN) begin
                  w_code_nxt  = FC_EARLY;
                  w_state_nxt = ST_IDLE;
               end else if (HOLD_LEN == 1) begin
                  w_pass_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_HOLD;
                  w_hold_nxt  = L_HLD_ONE;
               end
            end else if (w_off_cur == L_DLY_MAX) begin
               w_code_nxt  = FC_TIMEOUT;
               w_state_nxt = ST_IDLE;
            end else begin
               w_off_nxt = w_off_cur;
            end
         end
         ST_HOLD: begin
            if (rd) begin
               if (w_hold_inc == L_HOLD_LEN) begin
                  w_pass_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_hold_nxt = w_hold_inc;
               end
            end else begin
               w_code_nxt  = FC_SHORT;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments so all
   // registers update together from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_prev <= 1'b0;
         r_rd_prev <= 1'b0;
         r_off     <= '0;
         r_hold    <= '0;
         r_pass    <= 1'b0;
         r_fail    <= 1'b0;
         r_code    <= FC_NONE;
         r_cnt     <= '0;
         r_any     <= 1'b0;
      end else begin
         r_wr_prev <= wr;
         r_rd_prev <= rd;
         r_off     <= w_off_nxt;
         r_hold    <= w_hold_nxt;
         r_pass    <= w_pass_nxt;
         r_fail    <= w_fail_nxt;
         // clr wins over a coincident violation: it is not recorded.
         if (clr) begin
            r_code <= FC_NONE;
            r_cnt  <= '0;
            r_any  <= 1'b0;
         end else if (w_fail_nxt) begin
            r_code <= w_code_nxt;
            r_any  <= 1'b1;
            if (r_cnt != '1) begin
               r_cnt <= r_cnt + L_CNT_ONE;
            end
         end
      end
   end

   assign pass      = r_pass;
   assign fail      = r_fail;
   assign fail_code = r_code;
   assign err_cnt   = r_cnt;
   assign any_err   = r_any;

endmodule : rdwr_chk_channel

// File: rtl/rdwr_protocol_checker.sv
// ---------------------------------------------------------------------------
// rdwr_protocol_checker
// NUM_CH independent wr->rd timing checkers plus a global sticky error flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear of counters, codes and sticky flag
//   wr, rd       per-channel request inputs (NUM_CH bits)
//   pass, fail   per-channel one-cycle result pulses
//   fail_code    per-channel last violation code, FC_W bits each
//   err_cnt      per-channel saturating violation count, CNT_W bits each
//   any_err      OR of all per-channel sticky flags
// ---------------------------------------------------------------------------
module rdwr_protocol_checker
   import rdwr_chk_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int DLY_MIN      = 2,
   parameter int DLY_MAX      = 2,
   parameter int HOLD_LEN     = 2,
   parameter int CHECK_ORPHAN = 1,
   parameter int CNT_W        = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic [NUM_CH-1:0]       wr,
   input  logic [NUM_CH-1:0]       rd,
   output logic [NUM_CH-1:0]       pass,
   output logic [NUM_CH-1:0]       fail,
   output logic [FC_W*NUM_CH-1:0]  fail_code,
   output logic [CNT_W*NUM_CH-1:0] err_cnt,
   output logic                    any_err
);

   logic [NUM_CH-1:0] w_any_err;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      rdwr_chk_channel #(
         .DLY_MIN      (DLY_MIN),
         .DLY_MAX      (DLY_MAX),
         .HOLD_LEN     (HOLD_LEN),
         .CHECK_ORPHAN (CHECK_ORPHAN),
         .CNT_W        (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .clr       (clr),
         .wr        (wr[g]),
         .rd        (rd[g]),
         .pass      (pass[g]),
         .fail      (fail[g]),
         .fail_code (fail_code[g*FC_W +: FC_W]),
         .err_cnt   (err_cnt[g*CNT_W +: CNT_W]),
         .any_err   (w_any_err[g])
      );
   end

   assign any_err = |w_any_err;

endmodule : rdwr_protocol_checker

// File: tb/tb_rdwr_protocol_checker.sv
// ---------------------------------------------------------------------------
// tb_rdwr_protocol_checker
// Two checker instances share the same wr/rd stimulus: one with default
// parameters (4 channels) and one with a different timing window, a 2-bit
// counter and orphan checking disabled (2 channels). A timestamp-based
// reference model predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_rdwr_protocol_checker;

   localparam int NA = 4;
   localparam int NB = 2;
   localparam int B_MIN  = 1;
   localparam int B_MAX  = 3;
   localparam int B_HOLD = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic [3:0]  wr;
   logic [3:0]  rd;

   logic [NA-1:0]   pass_a, fail_a;
   logic [3*NA-1:0] fail_code_a;
   logic [8*NA-1:0] err_cnt_a;
   logic            any_a;
   logic [NB-1:0]   pass_b, fail_b;
   logic [3*NB-1:0] fail_code_b;
   logic [2*NB-1:0] err_cnt_b;
   logic            any_b;

   always #5 clk = ~clk;

   rdwr_protocol_checker dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .rd(rd),
      .pass(pass_a), .fail(fail_a), .fail_code(fail_code_a),
      .err_cnt(err_cnt_a), .any_err(any_a)
   );

   rdwr_protocol_checker #(
      .NUM_CH(NB), .DLY_MIN(B_MIN), .DLY_MAX(B_MAX), .HOLD_LEN(B_HOLD),
      .CHECK_ORPHAN(0), .CNT_W(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr[NB-1:0]), .rd(rd[NB-1:0]),
      .pass(pass_b), .fail(fail_b), .fail_code(fail_code_b),
      .err_cnt(err_cnt_b), .any_err(any_b)
   );

   // Reference channel: t_wr = edge index of the pending wr rise (-1 none),
   // t_rd = edge index at which an in-window rd rise was accepted (-1 none).
   typedef struct packed {
      int t_wr;
      int t_rd;
      bit pw;
      bit pr;
      bit pass;
      bit fail;
      int code;
      int cnt;
      bit any;
   } ch_m_t;

   ch_m_t ma [NA];
   ch_m_t mb [NB];
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic ch_m_t m_clear();
      ch_m_t m;
      m = '0;
      m.t_wr = -1;
      m.t_rd = -1;
      return m;
   endfunction

   function automatic ch_m_t m_edge(input ch_m_t mi, input bit w, input bit r,
                                    input bit c, input int t, input int dmin,
                                    input int dmax, input int hlen,
                                    input bit orph, input int cmax);
      ch_m_t m;
      bit wr_r, rd_r, ps;
      int code;
      m = mi;
      wr_r = w && !m.pw;
      rd_r = r && !m.pr;
      m.pw = w;
      m.pr = r;
      ps = 0;
      code = 0;
      if (m.t_rd >= 0) begin
         if (r) begin
            if (t - m.t_rd + 1 == hlen) begin
               ps = 1; m.t_rd = -1; m.t_wr = -1;
            end
         end else begin
            code = 3; m.t_rd = -1; m.t_wr = -1;
         end
      end else if (m.t_wr >= 0) begin
         if (wr_r) begin
            code = 4; m.t_wr = t;
         end else if (rd_r) begin
            if (t - m.t_wr < dmin) begin
               code = 1; m.t_wr = -1;
            end else if (hlen == 1) begin
               ps = 1; m.t_wr = -1;
            end else begin
               m.t_rd = t;
            end
         end else if (t - m.t_wr == dmax) begin
            code = 2; m.t_wr = -1;
         end
      end else begin
         if (wr_r) begin
            if (rd_r) code = 1;
            else m.t_wr = t;
         end else if (rd_r && orph) begin
            code = 5;
         end
      end
      m.pass = ps;
      m.fail = (code != 0);
      if (c) begin
         m.code = 0; m.cnt = 0; m.any = 0;
      end else if (code != 0) begin
         m.code = code;
         m.any = 1;
         if (m.cnt < cmax) m.cnt++;
      end
      return m;
   endfunction

   task automatic compare_all();
      bit any_exp;
      any_exp = 0;
      for (int i = 0; i < NA; i++) begin
         check($sformatf("a%0d.pass", i), 32'(pass_a[i]), 32'(ma[i].pass));
         check($sformatf("a%0d.fail", i), 32'(fail_a[i]), 32'(ma[i].fail));
         check($sformatf("a%0d.code", i), 32'(fail_code_a[i*3 +: 3]), ma[i].code);
         check($sformatf("a%0d.cnt", i), 32'(err_cnt_a[i*8 +: 8]), ma[i].cnt);
         any_exp |= ma[i].any;
      end
      check("a.any_err", 32'(any_a), 32'(any_exp));
      any_exp = 0;
      for (int i = 0; i < NB; i++) begin
         check($sformatf("b%0d.pass", i), 32'(pass_b[i]), 32'(mb[i].pass));
         check($sformatf("b%0d.fail", i), 32'(fail_b[i]), 32'(mb[i].fail));
         check($sformatf("b%0d.code", i), 32'(fail_code_b[i*3 +: 3]), mb[i].code);
         check($sformatf("b%0d.cnt", i), 32'(err_cnt_b[i*2 +: 2]), mb[i].cnt);
         any_exp |= mb[i].any;
      end
      check("b.any_err", 32'(any_b), 32'(any_exp));
   endtask

   task automatic step(input logic [3:0] w, input logic [3:0] r, input bit c);
      @(negedge clk);
      wr = w; rd = r; clr = c;
      @(posedge clk);
      for (int i = 0; i < NA; i++)
         ma[i] = m_edge(ma[i], w[i], r[i], c, cyc, 2, 2, 2, 1'b1, 255);
      for (int i = 0; i < NB; i++)
         mb[i] = m_edge(mb[i], w[i], r[i], c, cyc, B_MIN, B_MAX, B_HOLD, 1'b0, 3);
      cyc++;
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; wr = '0; rd = '0; clr = 1'b0;
      for (int i = 0; i < NA; i++) ma[i] = m_clear();
      for (int i = 0; i < NB; i++) mb[i] = m_clear();
      #1;
      compare_all();
      repeat (2) @(negedge clk);
      check("rst.pass_fail", {pass_a, fail_a, pass_b, fail_b}, 32'h0);
      rst_n = 1'b1;
   endtask

   // Channel-0 transaction: wr rise at offset 0 (if wr_on) and optionally at
   // wr2, rd high for rd_len edges from rd_off. Tallies channel-0 results.
   task automatic txn(input bit wr_on, input int wr2, input int rd_off, input int rd_len,
                      output int n_pass, output int n_fail, output int first_code,
                      output int first_idx, output int nb_fail);
      bit w, r;
      n_pass = 0; n_fail = 0; first_code = 0; first_idx = -1; nb_fail = 0;
      for (int k = 0; k < 14; k++) begin
         w = (wr_on && k == 0) || (k == wr2);
         r = (rd_off >= 0) && (k >= rd_off) && (k < rd_off + rd_len);
         step({3'b000, w}, {3'b000, r}, 1'b0);
         if (pass_a[0]) n_pass++;
         if (fail_a[0]) begin
            if (n_fail == 0) begin
               first_code = int'(fail_code_a[2:0]);
               first_idx = k;
            end
            n_fail++;
         end
         if (fail_b[0]) nb_fail++;
      end
   endtask

   initial begin
      int np, nf, fc, fi, nbf;
      logic [3:0] w, r;
      rst_n = 1'b0; wr = '0; rd = '0; clr = 1'b0;
      for (int i = 0; i < NA; i++) ma[i] = m_clear();
      for (int i = 0; i < NB; i++) mb[i] = m_clear();
      #12;
      check("reset.a_outputs", {pass_a, fail_a, fail_code_a}, 32'h0);
      check("reset.a_err_cnt", err_cnt_a, 32'h0);
      check("reset.any", {any_a, any_b, err_cnt_b}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Legal transaction
      txn(1, -1, 2, 2, np, nf, fc, fi, nbf);
      check("legal.pass_cnt", np, 1);
      check("legal.fail_cnt", nf, 0);

      // rd held only one cycle
      step(4'h0, 4'h0, 1'b1);
      txn(1, -1, 2, 1, np, nf, fc, fi, nbf);
      check("short.fail_cnt", nf, 1);
      check("short.code", fc, 3);
      check("short.err_cnt", 32'(err_cnt_a[7:0]), 1);
      check("short.any_err", 32'(any_a), 1);

      // rd never rises: fail after the offset-2 edge
      txn(1, -1, -1, 0, np, nf, fc, fi, nbf);
      check("timeout.code", fc, 2);
      check("timeout.edge", fi, 2);

      // rd rises too early
      txn(1, -1, 1, 2, np, nf, fc, fi, nbf);
      check("early.code", fc, 1);
      check("early.fail_cnt", nf, 1);

      // rd with no wr: orphan on default instance, silent with orphan check off
      txn(0, -1, 2, 2, np, nf, fc, fi, nbf);
      check("orphan.code", fc, 5);
      check("orphan.b_no_fail", nbf, 0);

      // Same-edge wr and rd rise
      txn(1, -1, 0, 2, np, nf, fc, fi, nbf);
      check("same_edge.code", fc, 1);

      // Second wr rise while waiting, then timeout of the restarted window
      txn(1, 2, -1, 0, np, nf, fc, fi, nbf);
      check("overlap.code", fc, 4);
      check("overlap.edge", fi, 2);
      check("overlap.fail_cnt", nf, 2);

      // Counter saturation on the 2-bit instance, then clear
      step(4'h0, 4'h0, 1'b1);
      for (int n = 0; n < 5; n++) txn(1, -1, 1, 1, np, nf, fc, fi, nbf);
      check("sat.b_err_cnt", 32'(err_cnt_b[1:0]), 3);
      check("sat.b_any_err", 32'(any_b), 1);
      step(4'h0, 4'h0, 1'b1);
      check("clr.b_err_cnt", 32'(err_cnt_b[1:0]), 0);
      check("clr.b_any_err", 32'(any_b), 0);

      // Reset during HOLD discards the transaction; the next one passes
      step(4'h1, 4'h0, 1'b0);
      step(4'h0, 4'h0, 1'b0);
      step(4'h0, 4'h1, 1'b0);
      do_reset();
      txn(1, -1, 2, 2, np, nf, fc, fi, nbf);
      check("post_rst.pass_cnt", np, 1);
      check("post_rst.fail_cnt", nf, 0);

      // Random traffic on all channels against the model
      w = '0; r = '0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 5) == 0) w[i] = ~w[i];
            if ($urandom_range(0, 2) == 0) r[i] = ~r[i];
         end
         step(w, r, 1'b0);
         if (n == 300) begin
            do_reset();
            w = '0; r = '0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_rdwr_protocol_checker
